tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4:1 multiplexed link, where a transmitter scans its `d0`..`d3` inputs through a 4:1 mux under a 2-bit slot counter. The block accepts one sample per valid strobe and locks to frames using a slot-0 sync marker. It assembles each four-slot frame in a shadow buffer and updates the four parallel channel outputs together once the frame is complete. It sits directly after the link input in the combinational-logic teaching designs and feeds LEDs or downstream logic.

## Interface
- `WIDTH`, default 1: width of each channel sample and of the serial input.
- `clk` input 1: system clock. The design has one clock, and all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `din` input WIDTH: multiplexed sample for the current slot.
- `valid` input 1: `din`/`sync` are meaningful this cycle. Sampled only when high.
- `sync` input 1: marks the current sample as slot 0 (channel `d0`).
- `q0`, `q1`, `q2`, `q3` output WIDTH each: registered channel outputs, holding the last complete frame.
- `sel` output 2: slot index expected for the next valid sample.
- `locked` output 1: high while the block is in the LOCKED state.
- `frame_done` output 1: one-cycle pulse when `q0`..`q3` take a new frame.
- `err` output 1: one-cycle pulse on a framing error.

## Operation
- **States:** HUNT (reset state) and LOCKED. `locked` is 1 exactly when the state is LOCKED.
- **Internal registers:** 2-bit slot counter (drives `sel`) and a three-entry shadow buffer for slots 0–2.
- **`valid` low:**
  - No state, counter, shadow or output changes.
  - `frame_done` and `err` are 0.
- **HUNT, `valid & sync`:**
  - `shadow[0] <= din`, `sel <= 1`, go to LOCKED.
- **HUNT, `valid & !sync`:**
  - Sample discarded, `sel` stays 0.
  - No `err`, because hunting is not an error.
- **LOCKED, `valid`, `sel` = 0, `sync` = 1:**
  - `shadow[0] <= din`, `sel <= 1`.
- **LOCKED, `valid`, `sel` = 0, `sync` = 0 (lost frame):**
  - Pulse `err`, go to HUNT, `sel <= 0`, sample discarded.
  - `q0`..`q3` keep their previous values.
- **LOCKED, `valid`, `sel` in 1..2, `sync` = 0:**
  - `shadow[sel] <= din`, `sel <= sel + 1`.
- **LOCKED, `valid`, `sel` = 3, `sync` = 0 (frame complete):**
  - `q0 <= shadow[0]`, `q1 <= shadow[1]`, `q2 <= shadow[2]`, `q3 <= din`.
  - Pulse `frame_done`, `sel <= 0` (wraps 3→0).
- **LOCKED, `valid`, `sel` in 1..3, `sync` = 1 (early sync):**
  - Pulse `err` and discard the partial frame.
  - Treat the sample as a new slot 0: `shadow[0] <= din`, `sel <= 1`, stay LOCKED.
  - `q` outputs unchanged, no `frame_done`.
- **Channel outputs:**
  - `q0`..`q3` never update partially; all four change on the same edge, or none do.
  - Outputs are never derived combinationally from `din`.
- **Counter width:** the slot counter is exactly 2 bits and wraps naturally. No other arithmetic is performed.

## Timing
- **Reset values:** on a rising edge with `rst` = 1:
  - State goes to HUNT.
  - `sel`, `q0`..`q3`, `frame_done`, `err`, `locked` and all shadow entries go to 0.
  - `rst` takes priority over `valid`.
- **Reset mid-frame:** the partial frame is lost, and the output frame is cleared to 0.
- **Frame-update latency:**
  - The slot-3 sample is captured on edge N.
  - `q0`..`q3` and `frame_done` = 1 are visible after edge N, for the cycle N..N+1.
  - `frame_done` returns to 0 after edge N+1 unless another frame completes there.
- **`err` timing:** `err` is visible for the one cycle after the offending edge.
- **Back-to-back samples:**
  - `valid` may be high every cycle, so the minimum frame is 4 cycles.
  - Gaps of any length between samples are allowed.
- **Mutual exclusion:** `frame_done` and `err` are never high in the same cycle.

## Test plan
- **Reset defaults:** hold `rst` for 2 cycles, then release.
  - All outputs are 0 and `locked` = 0.
- **Frame lock and update:** with WIDTH=1, send valid samples (sync,din) = (1,1),(0,0),(0,1),(0,1) on consecutive cycles.
  - After the 4th edge: `q0..q3` = 1,0,1,1 and `frame_done` high for exactly 1 cycle.
  - `locked` = 1 from after the 1st edge, and `sel` sequence is 1,2,3,0.
- **Gapped valid:** repeat the same frame with `valid` low for 3 cycles between samples.
  - Same outputs.
  - `sel` holds during the gaps and `frame_done` pulses once.
- **Early sync:** after one good frame (1,0,1,1), send (1,0),(0,1),(1,1),(0,0),(0,0),(0,1).
  - `err` pulses after the 3rd sample.
  - The next frame completes as `q` = 1,0,0,1 on the 6th sample.
  - `q` unchanged before that.
- **Lost frame:** after lock and one complete frame, send a valid sample with `sync` = 0 at `sel` = 0.
  - `err` pulses, `locked` falls to 0, `q` holds.
  - Samples without sync are ignored until the next sync.
- **Reset mid-frame:** assert `rst` after 2 samples of a frame.
  - All outputs are 0 and `locked` = 0.
  - A subsequent full frame (1,1),(0,1),(0,1),(0,0) yields `q` = 1,1,1,0.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 time-division multiplexed link.
// Locks to frames on the slot-0 sync marker and collects slots 0..2 in a
// shadow buffer. All four channel outputs are updated together when the
// slot-3 sample arrives. Framing errors send the block back to hunting for
// sync, or restart the frame on an early sync marker.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             frame_done,
  output logic             err
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  assign locked = (state == LOCKED);

  // Frame tracking: the slot counter, shadow buffer, frame commit and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      sel        <= 2'd0;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
      q0         <= '0;
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (valid) begin
        if (state == HUNT) begin
          // Samples without sync carry no frame position, so they are dropped.
          if (sync) begin
            shadow0 <= din;
            sel     <= 2'd1;
            state   <= LOCKED;
          end
        end else if (sync) begin
          // A sync outside slot 0 abandons the partial frame and restarts it.
          if (sel != 2'd0) begin
            err <= 1'b1;
          end
          shadow0 <= din;
          sel     <= 2'd1;
        end else begin
          case (sel)
            2'd0: begin
              err   <= 1'b1;
              state <= HUNT;
              sel   <= 2'd0;
            end
            2'd1: begin
              shadow1 <= din;
              sel     <= 2'd2;
            end
            2'd2: begin
              shadow2 <= din;
              sel     <= 2'd3;
            end
            default: begin
              q0         <= shadow0;
              q1         <= shadow1;
              q2         <= shadow2;
              q3         <= din;
              frame_done <= 1'b1;
              sel        <= sel + 2'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 with directed frames.
// Expected frame/error events are queued as stimulus is issued; a monitor
// pops them whenever the DUT raises frame_done or err.
module tb_tdm_demux4;

  localparam int WIDTH = 1;

  typedef struct packed {
    logic             is_err;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic [WIDTH-1:0] e3;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             valid;
  logic             sync;
  logic [WIDTH-1:0] q0, q1, q2, q3;
  logic [1:0]       sel;
  logic             locked;
  logic             frame_done;
  logic             err;

  int compared   = 0;
  int mismatched = 0;
  exp_t exp_q[$];

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid     (valid),
    .sync      (sync),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .sel       (sel),
    .locked    (locked),
    .frame_done(frame_done),
    .err       (err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the following rising edge
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    valid = v;
    sync  = s;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic expectFrame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    exp_q.push_back({1'b0, a, b, c, d});
  endtask

  task automatic expectErr(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    exp_q.push_back({1'b1, a, b, c, d});
  endtask

  task automatic checkQ(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    checkOutput({tag, "_q0"}, 32'(q0), 32'(a));
    checkOutput({tag, "_q1"}, 32'(q1), 32'(b));
    checkOutput({tag, "_q2"}, 32'(q2), 32'(c));
    checkOutput({tag, "_q3"}, 32'(q3), 32'(d));
  endtask

  // Monitor: every frame_done or err pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (frame_done && err) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL excl: frame_done=%0b err=%0b both high", frame_done, err);
      end else if (frame_done || err) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_event: frame_done=%0b err=%0b, none expected", frame_done, err);
        end else begin
          e = exp_q.pop_front();
          checkOutput("evt_err", 32'(err), 32'(e.is_err));
          checkOutput("evt_q0", 32'(q0), 32'(e.e0));
          checkOutput("evt_q1", 32'(q1), 32'(e.e1));
          checkOutput("evt_q2", 32'(q2), 32'(e.e2));
          checkOutput("evt_q3", 32'(q3), 32'(e.e3));
        end
      end
    end
  end

  // Directed scenarios
  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    sync  = 1'b0;
    din   = '0;

    // Reset defaults
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    checkQ("rst", 0, 0, 0, 0);
    checkOutput("rst_sel", 32'(sel), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_err", 32'(err), 0);

    // Frame lock and update, back-to-back
    applyStimulus(1, 1, 1);
    checkOutput("lock_locked", 32'(locked), 1);
    checkOutput("lock_sel1", 32'(sel), 1);
    applyStimulus(1, 0, 0);
    checkOutput("lock_sel2", 32'(sel), 2);
    applyStimulus(1, 0, 1);
    checkOutput("lock_sel3", 32'(sel), 3);
    checkQ("lock_pre", 0, 0, 0, 0);
    expectFrame(1, 0, 1, 1);
    applyStimulus(1, 0, 1);
    checkOutput("lock_sel0", 32'(sel), 0);
    checkOutput("lock_fd", 32'(frame_done), 1);
    checkQ("lock", 1, 0, 1, 1);
    idle(1);
    checkOutput("lock_fd_clear", 32'(frame_done), 0);

    // Gapped valid: same frame with 3 idle cycles between samples
    applyStimulus(1, 1, 1);
    idle(3);
    checkOutput("gap_sel1", 32'(sel), 1);
    applyStimulus(1, 0, 0);
    idle(3);
    checkOutput("gap_sel2", 32'(sel), 2);
    applyStimulus(1, 0, 1);
    idle(3);
    checkOutput("gap_sel3", 32'(sel), 3);
    checkOutput("gap_fd_idle", 32'(frame_done), 0);
    expectFrame(1, 0, 1, 1);
    applyStimulus(1, 0, 1);
    checkQ("gap", 1, 0, 1, 1);
    idle(1);

    // Early sync on the third sample restarts the frame
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 1);
    expectErr(1, 0, 1, 1);
    applyStimulus(1, 1, 1);
    checkOutput("early_err", 32'(err), 1);
    checkOutput("early_sel", 32'(sel), 1);
    checkOutput("early_locked", 32'(locked), 1);
    applyStimulus(1, 0, 0);
    checkOutput("early_err_clear", 32'(err), 0);
    applyStimulus(1, 0, 0);
    checkQ("early_hold", 1, 0, 1, 1);
    expectFrame(1, 0, 0, 1);
    applyStimulus(1, 0, 1);
    checkQ("early", 1, 0, 0, 1);

    // Lost frame: no sync where slot 0 is expected
    expectErr(1, 0, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("lost_locked", 32'(locked), 0);
    checkOutput("lost_sel", 32'(sel), 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("hunt_sel", 32'(sel), 0);
    checkOutput("hunt_locked", 32'(locked), 0);
    checkQ("hunt_hold", 1, 0, 0, 1);

    // Reset mid-frame, with valid high to show reset priority
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 0);
    checkOutput("mid_sel", 32'(sel), 2);
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    sync  = 1'b1;
    din   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    sync  = 1'b0;
    #1;
    checkQ("midrst", 0, 0, 0, 0);
    checkOutput("midrst_sel", 32'(sel), 0);
    checkOutput("midrst_locked", 32'(locked), 0);
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    checkQ("post_pre", 0, 0, 0, 0);
    expectFrame(1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    checkQ("post", 1, 1, 1, 0);

    idle(3);
    checkOutput("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
